// File: rtl/npc_pkg.sv
// Shared NPC core constants: reset vector, instruction size and legal register counts.
package npc_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
   localparam int ILEN_BYTES = 4;
   localparam int NREG_RV32E = 16;
   localparam int NREG_RV32I = 32;

   function automatic bit nreg_legal(input int n);
      return (n == NREG_RV32E) || (n == NREG_RV32I);
   endfunction

endpackage

// File: rtl/gpr_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, with a lookup port per read port.
module gpr_scoreboard
   import npc_pkg::*;
#(
   parameter int NREG = 32,
   parameter int NRD  = 2,
   parameter int AW   = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_en,
   input  logic [AW-1:0]     clr_idx,
   input  logic              set_en,
   input  logic [AW-1:0]     set_idx,
   input  logic [NRD*AW-1:0] look_idx,
   output logic [NRD-1:0]    look_busy
);

   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_nxt;

   // Set is applied after clear so a new producer issued in the same cycle stays outstanding.
   always_comb begin
      busy_nxt = busy;
      if (clr_en && clr_idx != '0) busy_nxt[clr_idx] = 1'b0;
      if (set_en && set_idx != '0) busy_nxt[set_idx] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) busy <= '0;
      else     busy <= busy_nxt;
   end

   for (genvar k = 0; k < NRD; k++) begin : g_look
      assign look_busy[k] = busy[look_idx[k*AW +: AW]];
   end

endmodule

// File: rtl/gpr_bank.sv
// Parametrised GPR bank with write bypass, pending-write scoreboard and fetch PC.
module gpr_bank
   import npc_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              NREG     = 32,
   parameter int              NRD      = 2,
   parameter int              BYPASS   = 1,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
   parameter int              AW       = $clog2(NREG)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wen,
   input  logic [AW-1:0]        waddr,
   input  logic [XLEN-1:0]      wdata,
   input  logic [NRD*AW-1:0]    raddr,
   output logic [NRD*XLEN-1:0]  rdata,
   output logic [NRD-1:0]       rbusy,
   input  logic                 iss_valid,
   input  logic [AW-1:0]        iss_rd,
   input  logic                 pc_stall,
   input  logic                 pc_redir,
   input  logic [XLEN-1:0]      pc_target,
   output logic [XLEN-1:0]      pc,
   output logic                 pc_misalign
);

   if (!nreg_legal(NREG) || NRD < 1 || NRD > 4) begin : g_param_check
      $error("gpr_bank: illegal NREG/NRD combination");
   end

   localparam bit BYP = (BYPASS != 0);

   logic [XLEN-1:0] regs [NREG];
   logic [NRD-1:0]  sb_busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (wen && waddr != '0) begin
         regs[waddr] <= wdata;
      end
   end

   gpr_scoreboard #(.NREG(NREG), .NRD(NRD), .AW(AW)) u_sb (
      .clk       (clk),
      .rst       (rst),
      .clr_en    (wen),
      .clr_idx   (waddr),
      .set_en    (iss_valid),
      .set_idx   (iss_rd),
      .look_idx  (raddr),
      .look_busy (sb_busy)
   );

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0] ra;
      logic          hit;
      assign ra  = raddr[k*AW +: AW];
      assign hit = BYP && wen && (waddr == ra) && (ra != '0);
      assign rdata[k*XLEN +: XLEN] = (ra == '0) ? '0 : (hit ? wdata : regs[ra]);
      // A port being served by the bypass already has its value, so it is not busy.
      assign rbusy[k] = sb_busy[k] & ~hit;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         pc_misalign <= 1'b0;
      end else if (pc_redir) begin
         pc          <= {pc_target[XLEN-1:2], 2'b00};
         pc_misalign <= |pc_target[1:0];
      end else begin
         if (!pc_stall) pc <= pc + XLEN'(ILEN_BYTES);
         pc_misalign <= 1'b0;
      end
   end

endmodule

// File: doc/gpr_bank.md
# gpr_bank

Parametrised general-purpose register bank with an integrated program counter and a per-register pending-write scoreboard. It replaces the fixed 32x32, two-read-port register file in the NPC core and sits between decode (read ports, issue), writeback (write port) and fetch (PC). It adds configurable width, depth and read-port count, optional write-to-read bypass, scoreboard tracking, and PC stall/redirect.

## Interface

Parameters:
- XLEN, 32, data and PC width.
- NREG, 32, architectural register count; legal values 16 (RV32E) or 32.
- NRD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = reads return stored value.
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- AW, $clog2(NREG), derived address width; not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset rst, synchronous, active-high.
- wen  in  1  writeback enable.
- waddr  in  AW  writeback register index.
- wdata  in  XLEN  writeback data.
- raddr  in  NRD*AW  read indices, port k at [k*AW +: AW].
- rdata  out  NRD*XLEN  read data, port k at [k*XLEN +: XLEN].
- rbusy  out  NRD  port k register has an outstanding write.
- iss_valid  in  1  an instruction writing iss_rd is issued this cycle.
- iss_rd  in  AW  destination index of issued instruction.
- pc_stall  in  1  hold PC.
- pc_redir  in  1  load pc_target into PC.
- pc_target  in  XLEN  redirect target.
- pc  out  XLEN  current PC.
- pc_misalign  out  1  registered flag: last accepted redirect target had bits [1:0] != 0.

## Operation

- Register 0 is hardwired zero: writes to index 0 discarded; reads of index 0 return 0 and rbusy 0 regardless of bypass or scoreboard.
- Write: on edge with wen=1 and waddr!=0, reg[waddr] <= wdata.
- Read: combinational. If BYPASS=1 and wen=1 and waddr==raddr_k!=0, rdata_k = wdata; else rdata_k = reg[raddr_k].
- Scoreboard: busy[NREG] bits. On edge: if wen and waddr!=0, clear busy[waddr]; then if iss_valid and iss_rd!=0, set busy[iss_rd] (set wins on same index, same cycle — the new producer is outstanding). busy[0] constant 0.
- rbusy_k = busy[raddr_k] & ~(BYPASS & wen & waddr==raddr_k), i.e. a port being satisfied by bypass reports not busy.
- PC priority per edge: rst > pc_redir > pc_stall > increment. Increment: pc <= pc + 4, wraps modulo 2^XLEN (no carry out). Redirect: pc <= {pc_target[XLEN-1:2], 2'b00}; pc_misalign <= |pc_target[1:0]. pc_misalign cleared on next non-redirect update (increment or stall hold keeps it 0 after one cycle).
- Multiple read ports with the same index return identical data and busy.

## Timing

- Reset (sync): all registers 0, all busy 0, pc = RESET_PC, pc_misalign = 0. rst asserted mid-operation discards concurrent wen/iss_valid/pc_redir in that cycle.
- Read latency 0 cycles (combinational from raddr, and from wdata/wen when BYPASS=1).
- Write visible in rdata the cycle after wen (same cycle if BYPASS=1).
- busy set visible one cycle after iss_valid; cleared one cycle after wen (same cycle via bypass masking if BYPASS=1).
- PC: redirect takes effect one cycle after pc_redir; stall holds pc exactly for asserted cycles; first post-reset cycle shows RESET_PC, next shows RESET_PC+4 absent stall.

## Structure

- Shared package npc_pkg: RESET_PC default, ILEN_BYTES=4, legal NREG values.
- Sub-module gpr_scoreboard: busy vector, set/clear priority, NRD lookup ports; gpr_bank instantiates it and holds storage, bypass muxes and PC.
- Assertion: NREG in {16,32}, 1<=NRD<=4 at elaboration.

## Test plan

- Reset then idle 3 cycles -> pc 80000000, 80000004, 80000008, 8000000C; all rdata 0, rbusy 0.
- wen=1 waddr=5 wdata=DEADBEEF, raddr0=5 same cycle -> BYPASS=1: rdata0=DEADBEEF same cycle; BYPASS=0: old 0 then DEADBEEF next cycle.
- wen=1 waddr=0 wdata=FFFFFFFF -> reads of index 0 return 0 forever; iss_valid iss_rd=0 -> rbusy stays 0.
- iss_valid iss_rd=7; next cycle raddr1=7 -> rbusy1=1; wen waddr=7 with iss_valid iss_rd=7 same cycle -> busy[7] remains 1; later wen waddr=7 alone -> cleared.
- pc_stall=1 and pc_redir=1 pc_target=80001002 together -> pc=80001000, pc_misalign=1 one cycle, then 0; stall alone 2 cycles -> pc held.
- pc forced to FFFFFFFC via redirect, then increment -> pc=00000000; NREG=16 build: write index 15 then read -> value returned.
